// File: rtl/store_buffer_be.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_be
// Purpose  : MEM-stage store buffer. Checks store alignment, builds byte-lane
//            enables and lane-shifted write data, and queues legal stores in a
//            DEPTH-entry FIFO drained to the data bus by valid/ready.
//            Rejected stores raise a one-cycle AdES pulse.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [1:0]                 st_size,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_exc,
    output logic [ADDR_W-1:0]          st_badvaddr,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W/8-1:0]        bus_byteen,
    output logic [DATA_W-1:0]          bus_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_nb    = DATA_W / 8;
    localparam int c_off_w = $clog2(c_nb);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    // Queue state
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_exc;
    logic [ADDR_W-1:0]  r_badvaddr;

    // Entry storage (never reset; only read while occupied)
    logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
    logic [c_nb-1:0]    r_mem_be   [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];

    // Request decode
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_legal;
    logic               w_wr_en;
    logic [3:0]         w_nbytes;
    logic [2:0]         w_align_mask;
    logic [c_off_w-1:0] w_off;
    logic [c_nb-1:0]    w_lane_mask;
    logic [DATA_W-1:0]  w_data_mask;
    logic [ADDR_W-1:0]  w_entry_addr;
    logic [c_nb-1:0]    w_entry_be;
    logic [DATA_W-1:0]  w_entry_data;

    assign w_full    = (r_count == c_full_cnt);
    assign st_ready  = !w_full && !flush;
    assign bus_valid = (r_count != '0);
    assign w_push    = st_valid && st_ready;
    assign w_pop     = bus_valid && bus_ready;

    // Access size in bytes and the address bits that must be zero for it
    assign w_nbytes     = 4'd1 << st_size;
    assign w_align_mask = 3'(w_nbytes - 4'd1);
    assign w_off        = st_addr[c_off_w-1:0];

    // A dword on a 32-bit bus does not fit; anything misaligned is rejected
    assign w_legal = (w_nbytes <= 4'(c_nb)) && ((st_addr[2:0] & w_align_mask) == 3'd0);
    assign w_wr_en = w_push && w_legal;

    // Low b lanes / low 8b data bits; a full-width shift yields zero so the
    // complement covers the whole bus for the widest access
    assign w_lane_mask = ~({c_nb{1'b1}} << w_nbytes);
    assign w_data_mask = ~({DATA_W{1'b1}} << {w_nbytes, 3'b000});

    assign w_entry_addr = {st_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
    assign w_entry_be   = w_lane_mask << w_off;
    assign w_entry_data = (st_data & w_data_mask) << {w_off, 3'b000};

    // Head of queue is driven straight from storage
    assign bus_addr   = r_mem_addr[r_rd_ptr];
    assign bus_byteen = r_mem_be[r_rd_ptr];
    assign bus_wdata  = r_mem_data[r_rd_ptr];
    assign count      = r_count;

    assign st_exc      = r_exc;
    assign st_badvaddr = r_badvaddr;

    // Pointer and occupancy bookkeeping; flush empties the queue outright
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // AdES reporting: pulse for one cycle, faulting address held until next fault
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exc      <= 1'b0;
            r_badvaddr <= '0;
        end else begin
            r_exc <= w_push && !w_legal;
            if (w_push && !w_legal) begin
                r_badvaddr <= st_addr;
            end
        end
    end

    // Write the formatted entry at the tail
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_addr[r_wr_ptr] <= w_entry_addr;
            r_mem_be[r_wr_ptr]   <= w_entry_be;
            r_mem_data[r_wr_ptr] <= w_entry_data;
        end
    end

endmodule
`default_nettype wire
